// File: rtl/skid_pipeline_pkg.sv
// skid_pipeline_pkg: shared state encoding and counter width for the skid pipeline
package skid_pipeline_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;
  localparam int STALL_CNT_W = 32;
endpackage

// File: rtl/skid_stage.sv
// skid_stage: two-entry skid buffer; ready and valid are decoded from registered state only
module skid_stage
  import skid_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);
  skid_state_e state, state_nxt;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic in_fire, out_fire;
  assign in_fire  = data_in_valid && data_in_ready;
  assign out_fire = data_out_valid && data_out_ready;
  always_ff @(posedge clk_i or negedge arst_n)
    if (!arst_n) state <= EMPTY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == EMPTY) state_nxt = in_fire ? ONE : EMPTY;
    else if (state == ONE) state_nxt = (in_fire && !out_fire) ? FULL : (out_fire && !in_fire) ? EMPTY : ONE;
    else state_nxt = out_fire ? ONE : FULL;
  end
  always_comb begin
    data_in_ready  = state != FULL;
    data_out_valid = state != EMPTY;
    data_out       = main_q;
  end
  // main reloads from input when it is (or is about to be) vacant; skid catches the overflow beat
  always_ff @(posedge clk_i or negedge arst_n)
    if (!arst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (in_fire && (state == EMPTY || out_fire)) main_q <= data_in;
      else if (state == FULL && out_fire) main_q <= skid_q;
      if (state == ONE && in_fire && !out_fire) skid_q <= data_in;
    end
endmodule

// File: rtl/skid_pipeline.sv
// skid_pipeline: chain of NUM_STAGES skid stages (0 = passthrough).
// Optional saturating stall counter enabled by SKID_PIPELINE_STALL_CNT_EN.
module skid_pipeline
  import skid_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 1
) (
  input  logic                   clk_i,
  input  logic                   arst_n,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_out_valid,
  input  logic                   data_out_ready
`ifdef SKID_PIPELINE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);
  if (NUM_STAGES == 0) begin : g_pass
    assign data_out       = data_in;
    assign data_out_valid = data_in_valid;
    assign data_in_ready  = data_out_ready;
  end else begin : g_chain
    logic [DATA_WIDTH-1:0] d [NUM_STAGES+1];
    logic                  v [NUM_STAGES+1];
    logic                  r [NUM_STAGES+1];
    assign d[0]           = data_in;
    assign v[0]           = data_in_valid;
    assign data_in_ready  = r[0];
    assign data_out       = d[NUM_STAGES];
    assign data_out_valid = v[NUM_STAGES];
    assign r[NUM_STAGES]  = data_out_ready;
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      skid_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .clk_i         (clk_i),
        .arst_n        (arst_n),
        .data_in       (d[i]),
        .data_in_valid (v[i]),
        .data_in_ready (r[i]),
        .data_out      (d[i+1]),
        .data_out_valid(v[i+1]),
        .data_out_ready(r[i+1])
      );
    end
  end
`ifdef SKID_PIPELINE_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge arst_n)
    if (!arst_n) stall_count <= '0;
    else if (data_in_valid && !data_in_ready && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
`endif
endmodule

// File: tb/tb_skid_pipeline.sv
// tb_skid_pipeline: four DUTs (NUM_STAGES 0..3) sharing inputs, checked against a queue model
module tb_skid_pipeline;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [7:0] din = '0;
  logic vin = 1'b0;
  logic rout = 1'b0;
  logic [7:0] dout [4];
  logic vout [4];
  logic rdy [4];
`ifdef SKID_PIPELINE_STALL_CNT_EN
  logic [31:0] sc [4];
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    skid_pipeline #(.DATA_WIDTH(8), .NUM_STAGES(k)) dut (
      .clk_i         (clk),
      .arst_n        (arst_n),
      .data_in       (din),
      .data_in_valid (vin),
      .data_in_ready (rdy[k]),
      .data_out      (dout[k]),
      .data_out_valid(vout[k]),
      .data_out_ready(rout)
`ifdef SKID_PIPELINE_STALL_CNT_EN
      ,
      .stall_count   (sc[k])
`endif
    );
  end

  task automatic apply_reset();
    vin = 1'b0;
    rout = 1'b0;
    din = '0;
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    vin = 1'b1;
    din = 8'h3c;
    rout = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b0;
    #1;
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (vout[k] !== 1'b0 || dout[k] !== 8'h00 || rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset n=%0d valid=%b data=%h ready=%b want 0 00 1", k, vout[k], dout[k], rdy[k]);
      end
`ifdef SKID_PIPELINE_STALL_CNT_EN
      checks++;
      if (sc[k] !== 32'd0) begin
        errors++;
        $display("FAIL reset_stall n=%0d got=%0d want 0", k, sc[k]);
      end
`endif
    end
    vin = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic exp_v;
    apply_reset();
    rout = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c >= 1 && c <= 16);
      checks++;
      if (vout[1] !== exp_v || (exp_v && dout[1] !== 8'(c)) || rdy[1] !== 1'b1) begin
        errors++;
        $display("FAIL stream c=%0d valid=%b data=%h ready=%b want %b %h 1", c, vout[1], dout[1], rdy[1], exp_v, 8'(c));
      end
      vin = c < 16;
      din = 8'(c + 1);
    end
    vin = 1'b0;
  endtask

  task automatic test_capacity();
    logic [7:0] q[$];
    int acc = 0;
    int outn = 0;
    apply_reset();
    rout = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (rdy[3] !== (c < 6)) begin
        errors++;
        $display("FAIL cap_ready c=%0d got=%b want %b", c, rdy[3], c < 6);
      end
      vin = acc < 8;
      din = 8'hA0 + 8'(acc);
      if (vin && rdy[3]) begin
        q.push_back(din);
        acc++;
      end
    end
    checks++;
    if (acc != 6) begin
      errors++;
      $display("FAIL cap_accepted got=%0d want 6", acc);
    end
    for (int c = 0; c < 40 && outn < 8; c++) begin
      @(negedge clk);
      rout = 1'b1;
      if (vout[3]) begin
        checks++;
        if (q.size() == 0 || dout[3] !== q[0] || dout[3] !== 8'hA0 + 8'(outn)) begin
          errors++;
          $display("FAIL cap_order idx=%0d got=%h want %h", outn, dout[3], 8'hA0 + 8'(outn));
        end
        if (q.size() != 0) void'(q.pop_front());
        outn++;
      end
      vin = acc < 8;
      din = 8'hA0 + 8'(acc);
      if (vin && rdy[3]) begin
        q.push_back(din);
        acc++;
      end
    end
    checks++;
    if (outn != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL cap_drain got=%0d left=%0d want 8 0", outn, q.size());
    end
    vin = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int sent = 0;
    int got = 0;
    logic hold = 1'b0;
    logic r_before;
    apply_reset();
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      @(negedge clk);
      r_before = rdy[2];
      rout = 1'($urandom_range(0, 1));
      if (!hold) begin
        vin = (sent < 1000) && ($urandom_range(0, 1) == 1);
        din = 8'($urandom);
      end
      #1;
      checks++;
      if (rdy[2] !== r_before) begin
        errors++;
        $display("FAIL ready_comb c=%0d ready moved %b->%b between edges", c, r_before, rdy[2]);
      end
      if (vout[2] && rout) begin
        checks++;
        if (q.size() == 0 || dout[2] !== q[0]) begin
          errors++;
          $display("FAIL random_data beat=%0d got=%h want %h", got, dout[2], q.size() ? q[0] : 8'hxx);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      hold = vin && !rdy[2];
      if (vin && rdy[2]) begin
        q.push_back(din);
        sent++;
      end
      checks++;
      if (q.size() > 4) begin
        errors++;
        $display("FAIL random_capacity in_flight=%0d want <=4", q.size());
      end
    end
    checks++;
    if (got != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL random_count got=%0d left=%0d want 1000 0", got, q.size());
    end
    vin = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rout = 1'b0;
    vin = 1'b1;
    din = 8'h55;
    @(negedge clk);
    din = 8'h56;
    @(negedge clk);
    vin = 1'b0;
    checks++;
    if (rdy[1] !== 1'b0 || vout[1] !== 1'b1 || dout[1] !== 8'h55) begin
      errors++;
      $display("FAIL mid_full ready=%b valid=%b data=%h want 0 1 55", rdy[1], vout[1], dout[1]);
    end
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (vout[1] !== 1'b0 || dout[1] !== 8'h00 || rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset valid=%b data=%h ready=%b want 0 00 1", vout[1], dout[1], rdy[1]);
    end
    @(negedge clk);
    arst_n = 1'b1;
    rout = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (vout[1] !== 1'b0) begin
        errors++;
        $display("FAIL mid_discard c=%0d valid=%b data=%h want no beat", c, vout[1], dout[1]);
      end
    end
  endtask

  task automatic test_passthrough();
    for (int c = 0; c < 8; c++) begin
      din = 8'($urandom);
      vin = 1'($urandom_range(0, 1));
      rout = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (dout[0] !== din || vout[0] !== vin || rdy[0] !== rout) begin
        errors++;
        $display("FAIL passthrough data=%h valid=%b ready=%b want %h %b %b", dout[0], vout[0], rdy[0], din, vin, rout);
      end
    end
    vin = 1'b0;
  endtask

`ifdef SKID_PIPELINE_STALL_CNT_EN
  task automatic test_stall();
    apply_reset();
    rout = 1'b0;
    vin = 1'b1;
    din = 8'h11;
    repeat (10) @(negedge clk);
    checks++;
    if (sc[1] !== 32'd8) begin
      errors++;
      $display("FAIL stall_count got=%0d want 8", sc[1]);
    end
    vin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sc[1] !== 32'd8) begin
      errors++;
      $display("FAIL stall_hold got=%0d want 8", sc[1]);
    end
  endtask
`endif

  initial begin
    #200000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    arst_n = 1'b1;
    test_reset();
    test_stream();
    test_capacity();
    test_random();
    test_reset_mid();
    test_passthrough();
`ifdef SKID_PIPELINE_STALL_CNT_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
